// File: rtl/config_chain_loader.sv
// Configuration chain loader: serializes host words LSB-first into the fabric programming chain.
// Optional read-back CRC check of the loaded chain is enabled by defining CFG_LOADER_VERIFY_EN.
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BCNT_W-1:0] FULL_C = BCNT_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    FIN    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  word_buf;
  logic [BCNT_W-1:0]  buf_cnt;
  logic               load_shift;
  logic               last_shift;
  logic               accept;

  assign load_shift = (state == LOAD) && (buf_cnt != '0);
  assign last_shift = load_shift && (bit_cnt == LAST_C);
  assign accept     = cfg_valid && cfg_ready;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (last_shift) begin
`ifdef CFG_LOADER_VERIFY_EN
          state_nxt = VERIFY;
`else
          state_nxt = FIN;
`endif
        end
      end
`ifdef CFG_LOADER_VERIFY_EN
      VERIFY: if (bit_cnt == LAST_C) state_nxt = FIN;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode from registered state; only recirculation passes prog_out through.
  always_comb begin
    cfg_ready = (state == LOAD) && (buf_cnt == '0) && (bit_cnt < LEN_C);
    prog_en   = load_shift;
    prog_in   = 1'b0;
    busy      = (state == LOAD);
    done      = (state == FIN);
    if (state == LOAD) prog_in = word_buf[0];
`ifdef CFG_LOADER_VERIFY_EN
    if (state == VERIFY) begin
      prog_en = 1'b1;
      prog_in = prog_out;
      busy    = 1'b1;
    end
`endif
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      bit_cnt  <= '0;
      word_buf <= '0;
      buf_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt <= '0;
            buf_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            word_buf <= cfg_data;
            buf_cnt  <= FULL_C;
          end else if (load_shift) begin
            word_buf <= word_buf >> 1;
            if (last_shift) begin
              // Leftover bits of a partial last word are dropped here.
              buf_cnt <= '0;
`ifdef CFG_LOADER_VERIFY_EN
              bit_cnt <= '0;
`else
              bit_cnt <= bit_cnt + CNT_W'(1);
`endif
            end else begin
              buf_cnt <= buf_cnt - BCNT_W'(1);
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
`ifdef CFG_LOADER_VERIFY_EN
        VERIFY: bit_cnt <= bit_cnt + CNT_W'(1);
`endif
        default: ;
      endcase
    end
  end

`ifdef CFG_LOADER_VERIFY_EN
  logic [15:0] crc_load;
  logic [15:0] crc_chk;
  logic        error_r;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // crc_load tracks bits shifted in; crc_chk tracks the same bits coming back out the tail.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      crc_load <= 16'hFFFF;
      crc_chk  <= 16'hFFFF;
      error_r  <= 1'b0;
    end else if ((state == IDLE) && start) begin
      crc_load <= 16'hFFFF;
      crc_chk  <= 16'hFFFF;
      error_r  <= 1'b0;
    end else if (load_shift) begin
      crc_load <= crc_step(crc_load, word_buf[0]);
    end else if (state == VERIFY) begin
      crc_chk <= crc_step(crc_chk, prog_out);
      if (bit_cnt == LAST_C) error_r <= (crc_step(crc_chk, prog_out) != crc_load);
    end
  end

  assign error = error_r;
`else
  logic prog_out_unused;
  assign prog_out_unused = prog_out;
  assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: two instances (8-bit and 6-bit chains, 4-bit words)
// driving behavioural shift-register chain models.
module tb_config_chain_loader;

`ifdef CFG_LOADER_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8 = 1'b0, start6 = 1'b0;
  logic [3:0] cfg_data = 4'h0;
  logic       cfg_valid = 1'b0;
  logic       rdy8, pin8, pen8, pout8, busy8, done8, err8;
  logic       rdy6, pin6, pen6, pout6, busy6, done6, err6;

  logic [7:0] chain8 = 8'h00;
  logic [5:0] chain6 = 6'h00;
  int         n8 = 0, n6 = 0, cyc = 0, acc6 = 0, flip_at = 0;
  bit         flip_en = 1'b0;
  bit         stray_en = 1'b0;
  logic       log_in8 [256];
  logic       log_out8[256];
  int         stamp8  [256];
  logic       log_in6 [256];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign pout8 = chain8[7];
  assign pout6 = chain6[5];

  config_chain_loader #(.CHAIN_LEN(8), .WORD_W(4), .CNT_W(16)) dut8 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start8), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy8), .prog_in(pin8), .prog_en(pen8),
    .prog_out(pout8), .busy(busy8), .done(done8), .error(err8));

  config_chain_loader #(.CHAIN_LEN(6), .WORD_W(4), .CNT_W(16)) dut6 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start6), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy6), .prog_in(pin6), .prog_en(pen6),
    .prog_out(pout6), .busy(busy6), .done(done6), .error(err6));

  // Chain models: head at bit 0, tail at the MSB; optional single-bit upset on a chosen shift.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pen8 && !busy8) stray_en <= 1'b1;
    if (pen6 && !busy6) stray_en <= 1'b1;
    if (cfg_valid && rdy6) acc6 <= acc6 + 1;
    if (pen8 && n8 < 256) begin
      chain8 <= {chain8[6:0], pin8} ^ ((flip_en && n8 == flip_at) ? 8'h01 : 8'h00);
      log_in8[n8]  <= pin8;
      log_out8[n8] <= pout8;
      stamp8[n8]   <= cyc;
      n8 <= n8 + 1;
    end
    if (pen6 && n6 < 256) begin
      chain6 <= {chain6[4:0], pin6};
      log_in6[n6] <= pin6;
      n6 <= n6 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pack8(input int base, input int n, input bit outs);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < n; k++) s = {s[6:0], outs ? log_out8[base+k] : log_in8[base+k]};
    return s;
  endfunction

  function automatic logic [5:0] pack6(input int base);
    logic [5:0] s;
    s = 6'h00;
    for (int k = 0; k < 6; k++) s = {s[4:0], log_in6[base+k]};
    return s;
  endfunction

  task automatic pulse_start(input int sel);
    if (sel == 1) start6 = 1'b1; else start8 = 1'b1;
    step();
    start6 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic send(input int sel, input logic [3:0] d, input int delay);
    bit ok;
    ok = 1'b0;
    repeat (delay) step();
    cfg_data  = d;
    cfg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if ((sel == 1) ? rdy6 : rdy8) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    cfg_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_done(input int sel, input bit fin_start, output int dones);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if ((sel == 1) ? done6 : done8) begin
        dones++;
        if (fin_start) begin
          if (sel == 1) start6 = 1'b1; else start8 = 1'b1;
        end
      end else if (dones > 0) begin
        break;
      end
      step();
      start8 = 1'b0;
      start6 = 1'b0;
    end
  endtask

  initial begin
    int base, base6, acc_base, dones;

    // Reset state
    rst_n = 1'b0;
    #2;
    check("rst_outputs8", {rdy8, pen8, pin8, busy8, done8, err8}, 6'b0);
    check("rst_outputs6", {rdy6, pen6, pin6, busy6, done6, err6}, 6'b0);
    #20;
    rst_n = 1'b1;
    step();

    // Reset asserted while shifting
    pulse_start(0);
    check("load_ready", rdy8, 1'b1);
    check("load_busy", busy8, 1'b1);
    send(0, 4'h5, 0);
    check("shift_en", pen8, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midload_rst_outputs", {rdy8, pen8, pin8, busy8, done8, err8}, 6'b0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_idle", {busy8, rdy8, pen8}, 3'b000);

    // Back-to-back words 0x5, 0xA
    base = n8;
    pulse_start(0);
    send(0, 4'h5, 0);
    send(0, 4'hA, 0);
    run_done(0, 1'b0, dones);
    check("s2_dones", dones, 1);
    check("s2_shifts", n8 - base, 8 * (1 + VER));
    check("s2_seq", pack8(base, 8, 1'b0), 8'hA5);
    check("s2_gap_inword", stamp8[base+3] - stamp8[base+2], 1);
    check("s2_gap_bubble", stamp8[base+4] - stamp8[base+3], 2);
    check("s2_chain", chain8, 8'hA5);
    check("s2_error", err8, 1'b0);
    check("s2_idle", busy8, 1'b0);
`ifdef CFG_LOADER_VERIFY_EN
    check("s5_recirc_out", pack8(base + 8, 8, 1'b1), 8'hA5);
`endif

    // Starvation: second word offered late
    base = n8;
    pulse_start(0);
    send(0, 4'h5, 0);
    send(0, 4'hA, 8);
    run_done(0, 1'b0, dones);
    check("s3_dones", dones, 1);
    check("s3_shifts", n8 - base, 8 * (1 + VER));
    check("s3_seq", pack8(base, 8, 1'b0), 8'hA5);
    check("s3_starve_gap", stamp8[base+4] - stamp8[base+3], 6);
    check("s3_old_tail_out", pack8(base, 8, 1'b1), 8'hA5);
    check("s3_chain", chain8, 8'hA5);

    // Short chain, partial last word, extra word offered but never accepted
    base6    = n6;
    acc_base = acc6;
    pulse_start(1);
    send(1, 4'hF, 0);
    send(1, 4'h3, 0);
    cfg_data  = 4'h0;
    cfg_valid = 1'b1;
    run_done(1, 1'b0, dones);
    cfg_valid = 1'b0;
    check("s4_dones", dones, 1);
    check("s4_shifts", n6 - base6, 6 * (1 + VER));
    check("s4_seq", pack6(base6), 6'h3F);
    check("s4_accepts", acc6 - acc_base, 2);
    check("s4_chain", chain6, 6'h3F);
    check("s4_error", err6, 1'b0);

`ifdef CFG_LOADER_VERIFY_EN
    // Corrupt the last loaded bit so read-back disagrees with the load CRC
    base    = n8;
    flip_at = base + 7;
    flip_en = 1'b1;
    pulse_start(0);
    send(0, 4'h5, 0);
    send(0, 4'hA, 0);
    run_done(0, 1'b0, dones);
    flip_en = 1'b0;
    check("s5_flip_dones", dones, 1);
    check("s5_flip_error", err8, 1'b1);
    check("s5_flip_chain", chain8, 8'hA4);
    repeat (4) step();
    check("s5_error_sticky", err8, 1'b1);
    pulse_start(0);
    check("s5_error_cleared", err8, 1'b0);
    send(0, 4'h5, 0);
    send(0, 4'hA, 0);
    run_done(0, 1'b0, dones);
    check("s5_reload_error", err8, 1'b0);
    check("s5_reload_chain", chain8, 8'hA5);
`endif

    // start while busy and while in FIN must be ignored
    base = n8;
    pulse_start(0);
    send(0, 4'h5, 0);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    send(0, 4'hA, 0);
    run_done(0, 1'b1, dones);
    check("s6_dones", dones, 1);
    check("s6_shifts", n8 - base, 8 * (1 + VER));
    check("s6_chain", chain8, 8'hA5);
    repeat (3) step();
    check("s6_still_idle", {busy8, done8, pen8}, 3'b000);
    check("no_stray_shift", stray_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
